// File: rtl/inst_encode_loader.sv
// inst_encode_loader
//   Encodes symbolic MIPS instructions (mnemonic + fields) into 32-bit words,
//   buffers them in a small FIFO and writes them to consecutive instruction
//   memory word addresses starting at BASE_ADDR. Used to fill imem before the
//   core runs.
//
// Ports
//   Clk, Reset          clock (rising edge) and synchronous active-high reset
//   Start               1-cycle pulse, begins a load (honoured only in IDLE)
//   In_Valid/In_Ready   instruction stream handshake
//   In_Op               mnemonic: 0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 LW,6 SW,7 ADDI,
//                       8 ANDI,9 ORI,10 SLTI,11 XORI,12 BNE,13 J,14 JAL,15 LUI
//   In_Rs/Rt/Rd/Shamt   register fields and shift amount
//   In_Imm, In_Target   immediate / branch offset, jump target
//   In_Last             final instruction of the program
//   Imem_Wr_En/Ready    memory write request / acceptance
//   Imem_Addr/Wr_Data   word address and encoded word
//   Done                1-cycle pulse when the load completes
//   Overflow            sticky: address space ran out before In_Last
//   Word_Count          words written since Start
module inst_encode_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [3:0]        In_Op,
  input  logic [4:0]        In_Rs,
  input  logic [4:0]        In_Rt,
  input  logic [4:0]        In_Rd,
  input  logic [4:0]        In_Shamt,
  input  logic [15:0]       In_Imm,
  input  logic [25:0]       In_Target,
  input  logic              In_Last,
  output logic              Imem_Wr_En,
  input  logic              Imem_Ready,
  output logic [ADDR_W-1:0] Imem_Addr,
  output logic [31:0]       Imem_Wr_Data,
  output logic              Done,
  output logic              Overflow,
  output logic [ADDR_W:0]   Word_Count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   BASE_C = (ADDR_W + 1)'(BASE_ADDR);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  // Next address to be claimed by an accepted word; its MSB set means every
  // address has been claimed, so acceptance stops before the FIFO drains.
  logic [ADDR_W:0]   claim_addr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              addr_exhausted;
  logic              last_slot;
  logic              push;
  logic              pop;
  logic [31:0]       enc_word;

  assign fifo_full      = (fifo_cnt == FULL_CNT);
  assign fifo_empty     = (fifo_cnt == '0);
  assign addr_exhausted = claim_addr[ADDR_W];
  assign last_slot      = (claim_addr == {1'b0, {ADDR_W{1'b1}}});

  // Full FIFO blocks acceptance even if a pop happens in the same cycle.
  assign In_Ready     = (state == LOAD) && !fifo_full && !addr_exhausted;
  assign push         = In_Valid && In_Ready;
  assign Imem_Wr_En   = !fifo_empty && ((state == LOAD) || (state == DRAIN));
  assign pop          = Imem_Wr_En && Imem_Ready;
  assign Imem_Wr_Data = Imem_Wr_En ? fifo_mem[rd_ptr] : '0;

  always_comb begin
    enc_word = '0;
    case (In_Op)
      4'd0:  enc_word = {6'd0, In_Rs, In_Rt, In_Rd, In_Shamt, 6'd32};
      4'd1:  enc_word = {6'd0, In_Rs, In_Rt, In_Rd, In_Shamt, 6'd34};
      4'd2:  enc_word = {6'd0, In_Rs, In_Rt, In_Rd, In_Shamt, 6'd36};
      4'd3:  enc_word = {6'd0, In_Rs, In_Rt, In_Rd, In_Shamt, 6'd37};
      4'd4:  enc_word = {6'd0, In_Rs, In_Rt, In_Rd, In_Shamt, 6'd42};
      4'd5:  enc_word = {6'd35, In_Rs, In_Rt, In_Imm};
      4'd6:  enc_word = {6'd43, In_Rs, In_Rt, In_Imm};
      4'd7:  enc_word = {6'd8,  In_Rs, In_Rt, In_Imm};
      4'd8:  enc_word = {6'd12, In_Rs, In_Rt, In_Imm};
      4'd9:  enc_word = {6'd13, In_Rs, In_Rt, In_Imm};
      4'd10: enc_word = {6'd10, In_Rs, In_Rt, In_Imm};
      4'd11: enc_word = {6'd14, In_Rs, In_Rt, In_Imm};
      4'd12: enc_word = {6'd5,  In_Rs, In_Rt, In_Imm};
      4'd13: enc_word = {6'd2,  In_Target};
      4'd14: enc_word = {6'd3,  In_Target};
      4'd15: enc_word = {6'd15, 5'd0, In_Rt, In_Imm};
    endcase
  end

  // Storage only; occupancy is tracked (and reset) by the pointers below.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      claim_addr <= BASE_C;
      Imem_Addr  <= BASE;
      Done       <= 1'b0;
      Overflow   <= 1'b0;
      Word_Count <= '0;
    end else begin
      Done <= 1'b0;

      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        claim_addr <= claim_addr + 1'b1;
      end

      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        Word_Count <= Word_Count + 1'b1;
        // Saturate at the top address instead of wrapping.
        if (Imem_Addr != '1) begin
          Imem_Addr <= Imem_Addr + 1'b1;
        end
      end

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        IDLE: begin
          if (Start) begin
            state      <= LOAD;
            Imem_Addr  <= BASE;
            claim_addr <= BASE_C;
            Word_Count <= '0;
            Overflow   <= 1'b0;
          end
        end
        LOAD: begin
          if (push && (In_Last || last_slot)) begin
            state <= DRAIN;
            if (last_slot && !In_Last) begin
              Overflow <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state <= DONE;
            Done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
